// File: rtl/fp_host_bridge_pkg.sv
`default_nettype none
//==============================================================================
// Module : fp_host_bridge_pkg
// Brief  : Field-element types, BN254 modulus and host-protocol constants.
// Rev    : 1.0 - initial release
//==============================================================================
package fp_host_bridge_pkg;

  localparam int K          = 17;
  localparam int N          = 17;
  localparam int FP_W       = K * N;
  localparam int BRAM_DEPTH = 10;

  typedef logic [FP_W-1:0] uint_fp_t;

  localparam uint_fp_t Mod =
    289'h2523648240000001BA344D80000000086121000000000013A700000000000013;

  localparam int FP_BYTES = 32;
  localparam int FP_BITS  = 8 * FP_BYTES;
  localparam int FP_PAD   = FP_W - FP_BITS;

  localparam logic [7:0] HOST_CMD_WRITE = 8'h01;
  localparam logic [7:0] HOST_CMD_READ  = 8'h02;
  localparam logic [7:0] HOST_CMD_START = 8'h03;
  localparam logic [7:0] HOST_ACK       = 8'hA5;
  localparam logic [7:0] HOST_NAK       = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_CHK     = 3'd3,
    ST_WR      = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_TX_DATA = 3'd6,
    ST_RESP    = 3'd7
  } host_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_byte_shifter.sv
`default_nettype none
//==============================================================================
// Module : fp_byte_shifter
// Brief  : 256-bit load / byte-shift register with a 5-bit byte counter.
// Rev    : 1.0 - initial release
//==============================================================================
module fp_byte_shifter
  import fp_host_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [FP_BITS-1:0] load_data,
  input  logic               shift,
  input  logic [7:0]         shift_in,
  output logic [FP_BITS-1:0] data,
  output logic               last
);

  localparam int CNT_W = $clog2(FP_BYTES);

  logic [FP_BITS-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = '0;
    end else if (shift) begin
      data_d = {data_q[FP_BITS-9:0], shift_in};
      cnt_d  = cnt_q + 1'b1;
    end else if (clr) begin
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data = data_q;
  assign last = (cnt_q == CNT_W'(FP_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/fp_host_bridge.sv
`default_nettype none
//==============================================================================
// Module : fp_host_bridge
// Brief  : UART byte-frame front end (WRITE/READ/START) for the pairing core.
//          Optional FP_HOST_BRIDGE_RANGE_CHK_EN rejects WRITE values >= Mod.
// Rev    : 1.0 - initial release
//==============================================================================
module fp_host_bridge
  import fp_host_bridge_pkg::*;
#(
  parameter int BRAM_LAT    = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  bram_we,
  output logic [BRAM_DEPTH-1:0] bram_waddr,
  output logic [FP_W-1:0]       bram_wdata,
  output logic [BRAM_DEPTH-1:0] bram_raddr,
  input  logic [FP_W-1:0]       bram_rdata,
  output logic                  start,
  output logic [6:0]            entry,
  input  logic                  core_busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam int WAIT_W = $clog2(BRAM_LAT + 1) + 1;

  host_state_t           state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  bram_we_q, bram_we_d;
  logic [BRAM_DEPTH-1:0] bram_waddr_q, bram_waddr_d;
  uint_fp_t              bram_wdata_q, bram_wdata_d;
  logic [BRAM_DEPTH-1:0] bram_raddr_q, bram_raddr_d;
  logic                  start_q, start_d;
  logic [6:0]            entry_q, entry_d;

  logic                  w_sh_clr, w_sh_load, w_sh_shift, w_sh_last;
  logic [7:0]            w_sh_in;
  logic [FP_BITS-1:0]    w_sh_data;
  logic                  w_rx_fire, w_tx_fire, w_timeout;
  logic [BRAM_DEPTH-1:0] w_addr_ext;
  logic                  w_rdata_unused;

  assign w_rx_fire      = rx_ready_q & rx_valid;
  assign w_tx_fire      = tx_valid_q & tx_ready;
  assign w_timeout      = (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
  assign w_addr_ext     = {{(BRAM_DEPTH-8){1'b0}}, rx_data};
  assign w_sh_in        = (state_q == ST_TX_DATA) ? 8'h00 : rx_data;
  assign w_rdata_unused = ^bram_rdata[FP_W-1:FP_BITS];

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    idle_d       = idle_q;
    wait_d       = wait_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    bram_we_d    = 1'b0;
    bram_waddr_d = bram_waddr_q;
    bram_wdata_d = bram_wdata_q;
    bram_raddr_d = bram_raddr_q;
    start_d      = 1'b0;
    entry_d      = entry_q;
    w_sh_clr     = 1'b0;
    w_sh_load    = 1'b0;
    w_sh_shift   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (w_rx_fire) begin
          if (rx_data == HOST_CMD_WRITE || rx_data == HOST_CMD_READ ||
              rx_data == HOST_CMD_START) begin
            cmd_d   = rx_data;
            state_d = ST_ADDR;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = HOST_NAK;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (w_rx_fire) begin
          idle_d = '0;
          if (cmd_q == HOST_CMD_WRITE) begin
            bram_waddr_d = w_addr_ext;
            w_sh_clr     = 1'b1;
            state_d      = ST_DATA;
          end else if (cmd_q == HOST_CMD_READ) begin
            bram_raddr_d = w_addr_ext;
            wait_d       = '0;
            state_d      = ST_RD_WAIT;
          end else begin
            // A busy core gets a NAK and no launch.
            entry_d    = rx_data[6:0];
            start_d    = ~core_busy;
            tx_valid_d = 1'b1;
            tx_data_d  = core_busy ? HOST_NAK : HOST_ACK;
            state_d    = ST_RESP;
          end
        end else if (w_timeout) begin
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_rx_fire) begin
          idle_d     = '0;
          w_sh_shift = 1'b1;
          if (w_sh_last) begin
`ifdef FP_HOST_BRIDGE_RANGE_CHK_EN
            state_d = ST_CHK;
`else
            bram_we_d    = 1'b1;
            bram_wdata_d = {{FP_PAD{1'b0}}, w_sh_data[FP_BITS-9:0], rx_data};
            state_d      = ST_WR;
`endif
          end
        end else if (w_timeout) begin
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_CHK: begin
`ifdef FP_HOST_BRIDGE_RANGE_CHK_EN
        if ({{FP_PAD{1'b0}}, w_sh_data} < Mod) begin
          bram_we_d    = 1'b1;
          bram_wdata_d = {{FP_PAD{1'b0}}, w_sh_data};
          state_d      = ST_WR;
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = HOST_NAK;
          state_d    = ST_RESP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_WR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HOST_ACK;
        state_d    = ST_RESP;
      end
      ST_RD_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(BRAM_LAT)) begin
          w_sh_load  = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = bram_rdata[FP_BITS-1:FP_BITS-8];
          state_d    = ST_TX_DATA;
        end
      end
      ST_TX_DATA: begin
        // Valid drops for one cycle after each accepted byte while the shifter advances.
        if (w_tx_fire) begin
          tx_valid_d = 1'b0;
          w_sh_shift = 1'b1;
          if (w_sh_last) state_d = ST_IDLE;
        end else if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = w_sh_data[FP_BITS-1:FP_BITS-8];
        end
      end
      ST_RESP: begin
        if (w_tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      idle_q       <= '0;
      wait_q       <= '0;
      rx_ready_q   <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      bram_we_q    <= 1'b0;
      bram_waddr_q <= '0;
      bram_wdata_q <= '0;
      bram_raddr_q <= '0;
      start_q      <= 1'b0;
      entry_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      idle_q       <= idle_d;
      wait_q       <= wait_d;
      rx_ready_q   <= rx_ready_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      bram_we_q    <= bram_we_d;
      bram_waddr_q <= bram_waddr_d;
      bram_wdata_q <= bram_wdata_d;
      bram_raddr_q <= bram_raddr_d;
      start_q      <= start_d;
      entry_q      <= entry_d;
    end
  end

  fp_byte_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_sh_clr),
    .load      (w_sh_load),
    .load_data (bram_rdata[FP_BITS-1:0]),
    .shift     (w_sh_shift),
    .shift_in  (w_sh_in),
    .data      (w_sh_data),
    .last      (w_sh_last)
  );

  assign rx_ready   = rx_ready_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign bram_we    = bram_we_q;
  assign bram_waddr = bram_waddr_q;
  assign bram_wdata = bram_wdata_q;
  assign bram_raddr = bram_raddr_q;
  assign start      = start_q;
  assign entry      = entry_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_host_bridge.sv
`default_nettype none
//==============================================================================
// Module : tb_fp_host_bridge
// Brief  : Scoreboard bench for fp_host_bridge with a latency-accurate BRAM model.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_fp_host_bridge;
  import fp_host_bridge_pkg::*;

  localparam int LAT = 2;
  localparam int TMO = 50;
`ifdef FP_HOST_BRIDGE_RANGE_CHK_EN
  localparam bit CHK_EN = 1'b1;
  localparam int WE_LAT = 2;
`else
  localparam bit CHK_EN = 1'b0;
  localparam int WE_LAT = 1;
`endif

  logic                  clk, rst;
  logic [7:0]            rx_data;
  logic                  rx_valid, rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid, tx_ready;
  logic                  bram_we;
  logic [BRAM_DEPTH-1:0] bram_waddr, bram_raddr;
  logic [FP_W-1:0]       bram_wdata, bram_rdata;
  logic                  start;
  logic [6:0]            entry;
  logic                  core_busy;

  fp_host_bridge #(.BRAM_LAT(LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
    .start(start), .entry(entry), .core_busy(core_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: contents fixed per address, read data appears LAT cycles after the address.
  logic [FP_W-1:0] bram_img [0:(1<<BRAM_DEPTH)-1];
  logic [FP_W-1:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    pipe[0] <= bram_img[bram_raddr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rdata = pipe[LAT-1];

  typedef struct packed {
    logic [BRAM_DEPTH-1:0] a;
    logic [FP_W-1:0]       d;
  } wr_t;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];
  logic [6:0] exp_st[$];

  int n_cmp = 0;
  int n_err = 0;
  bit tx_mode = 1'b0;

  task automatic chk(input string nm, input logic [FP_W-1:0] got, input logic [FP_W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every TX handshake, write strobe and start pulse.
  logic [7:0] m_tx;
  wr_t        m_wr;
  logic [6:0] m_st;
  bit         pv, pr;
  logic [7:0] pd;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        n_cmp++;
        if (!(tx_valid === 1'b1 && tx_data === pd)) begin
          n_err++;
          $display("FAIL tx_hold: got valid=%0b data=%02h expected valid=1 data=%02h", tx_valid, tx_data, pd);
        end
      end
      if (tx_valid && tx_ready) begin
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_err++;
          $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
        end else begin
          m_tx = exp_tx.pop_front();
          if (tx_data !== m_tx) begin
            n_err++;
            $display("FAIL tx_byte: got %02h expected %02h", tx_data, m_tx);
          end
        end
      end
      if (bram_we) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_err++;
          $display("FAIL we_unexpected: got addr %0h data %0h expected no write", bram_waddr, bram_wdata);
        end else begin
          m_wr = exp_wr.pop_front();
          if (bram_waddr !== m_wr.a || bram_wdata !== m_wr.d) begin
            n_err++;
            $display("FAIL bram_write: got addr %0h data %0h expected addr %0h data %0h",
                     bram_waddr, bram_wdata, m_wr.a, m_wr.d);
          end
        end
      end
      if (start) begin
        n_cmp++;
        if (exp_st.size() == 0) begin
          n_err++;
          $display("FAIL start_unexpected: got entry %0h expected no pulse", entry);
        end else begin
          m_st = exp_st.pop_front();
          if (entry !== m_st) begin
            n_err++;
            $display("FAIL start_entry: got %0h expected %0h", entry, m_st);
          end
        end
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_mode) tx_ready = ~tx_ready;
      else         tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit hs;
    n  = 0;
    hs = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!hs && n < 3000) begin
      @(negedge clk); hs = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!hs) begin
      n_cmp++; n_err++;
      $display("FAIL rx_accept: got no accept of %02h expected accept within 3000 cycles", b);
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [FP_BITS-1:0] v, input bit chk_lat);
    bit ok;
    int k;
    wr_t w;
    ok = !(CHK_EN && ({{FP_PAD{1'b0}}, v} >= Mod));
    if (ok) begin
      w.a = BRAM_DEPTH'(addr);
      w.d = {{FP_PAD{1'b0}}, v};
      exp_wr.push_back(w);
    end
    exp_tx.push_back(ok ? HOST_ACK : HOST_NAK);
    send_byte(HOST_CMD_WRITE);
    send_byte(addr);
    for (int i = FP_BYTES - 1; i >= 0; i--) begin
      send_byte(v[8*i +: 8]);
      if (i != 0) step($urandom_range(0, 2));
    end
    if (chk_lat && ok) begin
      k = 1;
      while (k <= 4) begin
        @(negedge clk);
        if (bram_we) break;
        k++;
      end
      chk("we_latency", FP_W'(k), FP_W'(WE_LAT));
    end
  endtask

  task automatic do_read(input logic [7:0] addr);
    logic [FP_W-1:0] img;
    img = bram_img[BRAM_DEPTH'(addr)];
    for (int i = FP_BYTES - 1; i >= 0; i--) exp_tx.push_back(img[8*i +: 8]);
    send_byte(HOST_CMD_READ);
    send_byte(addr);
  endtask

  task automatic do_start(input logic [7:0] addr, input bit busy);
    core_busy = busy;
    exp_tx.push_back(busy ? HOST_NAK : HOST_ACK);
    if (!busy) exp_st.push_back(addr[6:0]);
    send_byte(HOST_CMD_START);
    send_byte(addr);
  endtask

  task automatic do_bad(input logic [7:0] cmd);
    exp_tx.push_back(HOST_NAK);
    send_byte(cmd);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_st.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d tx %0d wr %0d start pending expected none",
               exp_tx.size(), exp_wr.size(), exp_st.size());
      exp_tx.delete(); exp_wr.delete(); exp_st.delete();
    end
    step(3);
  endtask

  task automatic check_rst();
    @(negedge clk);
    chk("rst_rx_ready",   FP_W'(rx_ready),   FP_W'(1));
    chk("rst_tx_valid",   FP_W'(tx_valid),   '0);
    chk("rst_tx_data",    FP_W'(tx_data),    '0);
    chk("rst_bram_we",    FP_W'(bram_we),    '0);
    chk("rst_bram_waddr", FP_W'(bram_waddr), '0);
    chk("rst_bram_wdata", bram_wdata,        '0);
    chk("rst_bram_raddr", FP_W'(bram_raddr), '0);
    chk("rst_start",      FP_W'(start),      '0);
    chk("rst_entry",      FP_W'(entry),      '0);
  endtask

  function automatic logic [FP_BITS-1:0] rand256();
    logic [FP_BITS-1:0] v;
    v = '0;
    for (int w = 0; w < 8; w++) v = {v[FP_BITS-33:0], 32'($urandom())};
    return v;
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [FP_W-1:0] t;
    logic [7:0] b;
    int r;
    for (int i = 0; i < (1 << BRAM_DEPTH); i++) begin
      t = '0;
      for (int w = 0; w < 10; w++) t = {t[FP_W-33:0], 32'($urandom())};
      bram_img[i] = t;
    end
    bram_img[5]      = '0;
    bram_img[5][288] = 1'b1;
    bram_img[5][7:0] = 8'hAB;

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; core_busy = 1'b0;
    step(3);
    check_rst();
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    do_write(8'h05, Mod[FP_BITS-1:0] - 1'b1, 1'b1);
    drain();

    tx_mode = 1'b1;
    do_read(8'h05);
    drain();
    tx_mode = 1'b0;

    do_start(8'h83, 1'b0);
    drain();
    do_start(8'h83, 1'b1);
    drain();

    do_bad(8'h7F);
    do_write(8'h11, rand256(), 1'b1);
    drain();

    send_byte(HOST_CMD_WRITE);
    send_byte(8'h40);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom()));
    step(TMO + 10);
    do_write(8'h41, rand256(), 1'b1);
    drain();

    send_byte(HOST_CMD_WRITE);
    send_byte(8'h22);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom()));
    rst = 1'b1;
    @(posedge clk); #1;
    check_rst();
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    do_write(8'h07, Mod[FP_BITS-1:0], 1'b1);
    drain();

    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      core_busy = 1'($urandom_range(0, 1));
      if (r == 0)      do_write(8'($urandom()), Mod[FP_BITS-1:0] + 256'($urandom_range(0, 2)) - 1'b1, 1'b1);
      else if (r <= 3) do_write(8'($urandom()), rand256(), 1'b1);
      else if (r <= 6) do_read(8'($urandom()));
      else if (r <= 8) do_start(8'($urandom()), 1'($urandom_range(0, 1)));
      else begin
        b = 8'($urandom());
        while (b == HOST_CMD_WRITE || b == HOST_CMD_READ || b == HOST_CMD_START) b = 8'($urandom());
        do_bad(b);
      end
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_host_bridge.md
# fp_host_bridge

Byte-level host front end for the BN254 pairing core, sitting between the UART byte core and the core's operand BRAM/sequencer. It parses host frames (WRITE / READ / START), assembles 256-bit big-endian field elements into `uint_fp_t` words for the BRAM write port, and serializes BRAM read data back out. It also issues the start pulse that launches a program at a given instruction entry.

## Interface
- `BRAM_LAT`, 2: BRAM read latency in cycles, from `bram_raddr` to `bram_rdata` valid.
- `TIMEOUT_CYC`, 1_000_000: idle cycles allowed mid-frame before the frame is dropped.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: byte from the UART receiver.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: bridge accepts a byte this cycle.
- `tx_data` out 8: byte to the UART transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: transmitter accepts a byte.
- `bram_we` out 1: one-cycle write strobe.
- `bram_waddr` out BRAM_DEPTH: write address.
- `bram_wdata` out K*N (289): `uint_fp_t` write data.
- `bram_raddr` out BRAM_DEPTH: read address.
- `bram_rdata` in K*N: read data.
- `start` out 1: one-cycle program launch pulse.
- `entry` out 7: program entry address, valid with `start`.
- `core_busy` in 1: core is executing.

## Operation
- A byte transfers on a cycle where valid and ready are both high. This applies to RX and TX.
- Frame byte 0 is the command: 0x01 WRITE, 0x02 READ, 0x03 START.
- Frame byte 1 is the address. It is zero-extended to BRAM_DEPTH bits for BRAM, and its low 7 bits form `entry`.
- WRITE carries 32 further data bytes, MSB first. They shift into a 256-bit register, and `bram_wdata` = {33'b0, value}. The write is followed by ACK 0xA5.
- READ: no payload. The bridge sends 32 bytes of `bram_rdata[255:0]`, MSB first; bits [288:256] are discarded. No ACK is sent.
- START: if `core_busy`=0, pulse `start` and send ACK 0xA5. Otherwise send NAK 0x5A and do not pulse `start`.
- Unknown command: consume only that byte, send NAK 0x5A, return to IDLE.
- States and transitions:
  - IDLE → ADDR on a command byte.
  - ADDR → DATA (WRITE), RD_WAIT (READ), or RESP (START).
  - DATA counts 32 bytes with a 5-bit counter, then → WR.
  - WR → RESP.
  - RD_WAIT counts BRAM_LAT cycles, latches `bram_rdata`, → TX_DATA.
  - TX_DATA shifts out 32 bytes, then → IDLE.
  - RESP holds the response byte until accepted, then → IDLE.
- `rx_ready` = 1 only in IDLE, ADDR and DATA. Bytes arriving in other states are back-pressured, not dropped.
- Timeout: in ADDR or DATA, the idle counter resets on each accepted byte. When it reaches TIMEOUT_CYC, the partial frame is discarded silently (no write, no response) → IDLE.
- Reset mid-frame aborts everything. There is no partial write, and any pending TX byte is withdrawn.

## Timing
- Reset values:
  - `rx_ready`=1 (IDLE).
  - `tx_valid`=0, `tx_data`=0.
  - `bram_we`=0, `bram_waddr`=0, `bram_wdata`=0, `bram_raddr`=0.
  - `start`=0, `entry`=0.
- WRITE: `bram_we` goes high exactly 1 cycle after the 32nd data byte is accepted, for 1 cycle. `tx_valid`=1 with 0xA5 on the next cycle.
- READ: `bram_raddr` is driven in the cycle after the address byte is accepted and held. Data is latched BRAM_LAT cycles later. The first `tx_valid` comes 1 cycle after the latch.
- TX: `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0. The next byte is presented the cycle after acceptance, so peak throughput is 1 byte / 2 cycles.
- START: `start` pulses in the cycle after the address byte is accepted, sampling `core_busy` in that same cycle. The ACK is presented together with the pulse.

## Configuration
- `FP_HOST_BRIDGE_RANGE_CHK_EN` defined: in WR, if the assembled value ≥ `Mod`, no write occurs (`bram_we` stays 0) and NAK 0x5A is sent in place of ACK. The compare takes 1 extra cycle, so `bram_we` comes 2 cycles after the last byte.
- Undefined: every value is written unchecked, with 1-cycle timing as above.

## Structure
- Package `CURVE_PARAMS` gains:
  - `HOST_CMD_WRITE`/`READ`/`START`, `HOST_ACK`, `HOST_NAK` localparams.
  - `FP_BYTES = 32`.
  - A `host_state_t` enum.
- The module uses `uint_fp_t`, `BRAM_DEPTH` and `Mod` from the existing packages.
- One natural sub-module: `fp_byte_shifter`, a 256-bit load/shift register with a byte counter, shared by RX assembly and TX serialization.

## Test plan
- WRITE addr 0x05, data 0x2523…0012 (`Mod`−1) → `bram_we` 1 cycle after the last byte, `bram_waddr`=5, `bram_wdata`=`Mod`−1, then TX 0xA5.
- READ addr 0x05, BRAM model returning 0x1_0000…00AB (bit 288 set) → 32 TX bytes 0x00…0x00,0xAB with `tx_ready` toggling 1-0. Every byte holds until accepted.
- START addr 0x83 with `core_busy`=0 → `start` pulse, `entry`=0x03, TX 0xA5. Repeat with `core_busy`=1 → no pulse, TX 0x5A.
- Command 0x7F → TX 0x5A. An immediately following WRITE frame completes normally.
- WRITE with only 10 data bytes, then silence for TIMEOUT_CYC (set to 50) → no `bram_we`, no TX, next frame accepted. Assert `rst` mid-DATA → outputs return to reset values.
- With the macro: WRITE of `Mod` exactly → no `bram_we`, TX 0x5A. Without it: the same write occurs, TX 0xA5.
